// File: rtl/clk_util_pkg.sv
// clk_util_pkg
//   Shared definitions for the clock-utility blocks (dividers, period_meter).
//   - meter_state_e       : period_meter FSM state encoding
//   - DEFAULT_COUNT_WIDTH : default counter / measurement width
//   - DEFAULT_MAX_COUNT   : default longest period, 2 s at 12 MHz
package clk_util_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_e;

  localparam int unsigned DEFAULT_COUNT_WIDTH = 25;
  localparam int unsigned DEFAULT_MAX_COUNT   = 24_000_000;

endpackage : clk_util_pkg

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
//   Brings an asynchronous level into the clk domain through a two-flop
//   synchroniser (s1, s2), then compares it with a history flop (s3)
//   to produce single-cycle edge strobes.
// Ports:
//   clk     in  system clock, rising edge
//   rst_n   in  asynchronous active-low reset, clears the whole chain
//   sig_i   in  asynchronous input level
//   rise_o  out one-cycle strobe on a synchronised 0->1 transition
//   fall_o  out one-cycle strobe on a synchronised 1->0 transition
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s1 may be metastable, so only s2 and s3 feed logic.
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule : sync_edge_detect

// File: rtl/period_meter.sv
// period_meter
//   Measures a slow free-running square wave in system clock cycles.
//   Each full input cycle (rising edge to rising edge) yields the period
//   and the high time, with a one-cycle valid strobe. If no rising edge
//   arrives within MAX_COUNT cycles a timeout strobe fires and the meter
//   re-arms on the next rising edge.
// Parameters:
//   COUNT_WIDTH  width of the cycle counter and measurement outputs
//   MAX_COUNT    longest accepted period; 2 <= MAX_COUNT < 2**COUNT_WIDTH
// Ports:
//   clk        in  system clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   sig_in     in  measured signal, asynchronous to clk
//   period     out cycles between the last two detected rising edges
//   high_time  out cycles from that rising edge to the following falling edge
//   valid      out one-cycle strobe, period/high_time updated
//   timeout    out one-cycle strobe, no rising edge within MAX_COUNT cycles
//   locked     out level, a valid measurement since reset or last timeout
module period_meter
  import clk_util_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int unsigned MAX_COUNT   = DEFAULT_MAX_COUNT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] period,
  output logic [COUNT_WIDTH-1:0] high_time,
  output logic                   valid,
  output logic                   timeout,
  output logic                   locked
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(MAX_COUNT);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic rise, fall;

  sync_edge_detect u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (sig_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  meter_state_e           state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] hi_cap_q, hi_cap_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic [COUNT_WIDTH-1:0] high_time_q, high_time_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic                   locked_q, locked_d;

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned; a missed path would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_cap_d    = hi_cap_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;
    locked_d    = locked_q;

    unique case (state_q)
      IDLE: begin
        // Waiting for the first rising edge; falls carry no meaning yet.
        cnt_d = '0;
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
        end
      end

      MEASURE: begin
        // cnt already counts the edge cycle as 1, so a falling edge seen
        // now gives the high time directly.
        if (fall) begin
          hi_cap_d = cnt_q;
        end

        // A rise on the MAX_COUNT cycle is still a valid full period, so
        // it is tested before the timeout.
        if (rise) begin
          period_d    = cnt_q;
          high_time_d = hi_cap_q;
          valid_d     = 1'b1;
          locked_d    = 1'b1;
          cnt_d       = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_cap_q    <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_cap_q    <= hi_cap_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      locked_q    <= locked_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign locked    = locked_q;

endmodule : period_meter

// File: tb/tb_period_meter.sv
// tb_period_meter
//   Directed bench for period_meter with MAX_COUNT = 100. sig_in is driven
//   1 ns after falling clk edges; a monitor records every valid/timeout
//   strobe with a cycle stamp, and the main sequence checks those records
//   and the output ports against hand-computed values.
module tb_period_meter;

  localparam int unsigned CW   = 25;
  localparam int unsigned MAXC = 100;

  logic          clk;
  logic          rst_n;
  logic          sig_in;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          valid;
  logic          timeout;
  logic          locked;

  period_meter #(
    .COUNT_WIDTH (CW),
    .MAX_COUNT   (MAXC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Strobe records, updated on falling edges.
  longint        cyc = 0;
  int            valid_cnt = 0;
  int            timeout_cnt = 0;
  int            both_cnt = 0;
  int            fast_ok_cnt = 0;
  longint        last_valid_cyc = 0;
  longint        prev_valid_cyc = 0;
  longint        timeout_cyc = 0;
  logic [CW-1:0] last_period = '0;
  logic [CW-1:0] last_high = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt      <= valid_cnt + 1;
      last_period    <= period;
      last_high      <= high_time;
      prev_valid_cyc <= last_valid_cyc;
      last_valid_cyc <= cyc;
      if (period == 2 && high_time == 1) fast_ok_cnt <= fast_ok_cnt + 1;
    end
    if (timeout) begin
      timeout_cnt <= timeout_cnt + 1;
      timeout_cyc <= cyc;
    end
    if (valid && timeout) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next falling edge, after monitor updates.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      repeat (hi) step();
      sig_in = 1'b0;
      repeat (lo) step();
    end
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int vc;

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) step();
    check("rst_period",    period,    0);
    check("rst_high_time", high_time, 0);
    check("rst_valid",     valid,     0);
    check("rst_timeout",   timeout,   0);
    check("rst_locked",    locked,    0);
    rst_n = 1'b1;
    repeat (2) step();

    // 50 % duty, period 10: six rises -> five valids.
    wave(5, 5, 6);
    check("sq_valid_count", valid_cnt, 5);
    check("sq_period",      last_period, 10);
    check("sq_high_time",   last_high, 5);
    check("sq_interval",    last_valid_cyc - prev_valid_cyc, 10);
    check("sq_locked",      locked, 1);
    check("sq_no_timeout",  timeout_cnt, 0);

    // Duty 3/7: the first new rise still reports the old 5-cycle high time.
    wave(3, 7, 2);
    check("duty_valid_count", valid_cnt, 7);
    check("duty_period",      last_period, 10);
    check("duty_high_time",   last_high, 3);

    // Stuck low: timeout 100 cycles after the last rise's valid.
    repeat (100) step();
    check("stuck_timeout_count", timeout_cnt, 1);
    check("stuck_timeout_delay", timeout_cyc - last_valid_cyc, 100);
    check("stuck_locked",        locked, 0);
    check("stuck_period_hold",   period, 10);
    // This rise only re-arms; the next rise comes exactly 100 cycles later.
    wave(5, 95, 1);
    check("rearm_no_valid", valid_cnt, 7);

    // Rise exactly when cnt reaches MAX_COUNT: valid wins, no timeout.
    wave(5, 5, 1);
    check("max_valid_count", valid_cnt, 8);
    check("max_period",      last_period, 100);
    check("max_high_time",   last_high, 5);
    check("max_no_timeout",  timeout_cnt, 1);
    check("max_locked",      locked, 1);

    // Toggle every clk: first rise reports 10/5, the other nine 2/1.
    wave(1, 1, 10);
    repeat (5) step();
    check("fast_valid_count", valid_cnt, 18);
    check("fast_2_1_count",   fast_ok_cnt, 9);
    check("fast_period",      last_period, 2);
    check("fast_high_time",   last_high, 1);

    // Reset asserted between clock edges, mid-period.
    sig_in = 1'b1;
    repeat (3) step();
    #2;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    #1;
    check("arst_period",    period,    0);
    check("arst_high_time", high_time, 0);
    check("arst_valid",     valid,     0);
    check("arst_timeout",   timeout,   0);
    check("arst_locked",    locked,    0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    vc = valid_cnt;
    wave(5, 5, 1);
    check("post_rst_first_rise", valid_cnt, vc);
    check("post_rst_locked0",    locked, 0);
    wave(5, 5, 1);
    check("post_rst_second_rise", valid_cnt, vc + 1);
    check("post_rst_period",      last_period, 10);
    check("post_rst_high_time",   last_high, 5);
    check("post_rst_locked",      locked, 1);

    check("never_valid_and_timeout", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_period_meter
